// File: rtl/jtdd_snd_mix.sv
// Stereo sound mixer: time-multiplexed MAC over CH signed channels with
// per-channel left/right gains, shadowed per sample, saturated output.
module jtdd_snd_mix #(
   parameter int CH   = 4,
   parameter int IW   = 16,
   parameter int GW   = 8,
   parameter int FRAC = 4,
   parameter int OW   = 16,
   parameter int AW   = $clog2(CH) + 1
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 cen_smp,
   input  logic [CH*IW-1:0]     ch_in,
   input  logic                 cs,
   input  logic                 wr_n,
   input  logic [AW-1:0]        addr,
   input  logic [GW-1:0]        din,
   output logic signed [OW-1:0] left,
   output logic signed [OW-1:0] right,
   output logic                 sample,
   output logic                 clip,
   output logic                 busy
);
   localparam int CW  = (AW > 1) ? AW - 1 : 1;
   localparam int PW  = IW + GW + 1;
   localparam int ACW = PW + $clog2(CH);

   localparam logic [GW-1:0]         UNITY = {{(GW-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [CW-1:0]         LAST  = CW'(CH - 1);
   localparam logic signed [ACW-1:0] OMAX  = {{(ACW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACW-1:0] OMIN  = ~OMAX;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;

   logic [GW-1:0]         gain_l [CH];
   logic [GW-1:0]         gain_r [CH];
   logic [GW-1:0]         gl_sh  [CH];
   logic [GW-1:0]         gr_sh  [CH];
   logic signed [IW-1:0]  in_sh  [CH];

   logic [1:0]            state;
   logic [CW-1:0]         idx;
   logic signed [ACW-1:0] acc_l;
   logic signed [ACW-1:0] acc_r;

   logic                  wr_en;
   logic [CW-1:0]         wch;
   logic signed [PW-1:0]  in_x;
   logic signed [PW-1:0]  gl_x;
   logic signed [PW-1:0]  gr_x;
   logic signed [PW-1:0]  prod_l;
   logic signed [PW-1:0]  prod_r;
   logic [OW:0]           sat_l;
   logic [OW:0]           sat_r;

   // Scale by the gain fraction (floor) and clamp; MSB of the result flags a clamp.
   function automatic logic [OW:0] sat_fn(input logic signed [ACW-1:0] a);
      logic signed [ACW-1:0] s;
      s = a >>> FRAC;
      if (s > OMAX) begin
         sat_fn = {1'b1, OMAX[OW-1:0]};
      end else if (s < OMIN) begin
         sat_fn = {1'b1, OMIN[OW-1:0]};
      end else begin
         sat_fn = {1'b0, s[OW-1:0]};
      end
   endfunction

   assign wr_en = cs & ~wr_n;
   assign wch   = CW'(addr >> 1);

   // Gain bank: writes to channel indices at or beyond CH match no register.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         for (int c = 0; c < CH; c++) begin
            gain_l[c] <= UNITY;
            gain_r[c] <= UNITY;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (wr_en && wch == CW'(c)) begin
               if (addr[0]) gain_r[c] <= din;
               else         gain_l[c] <= din;
            end
         end
      end
   end

   // Products for the channel currently selected, plus saturated results.
   always_comb begin
      in_x   = PW'(in_sh[idx]);
      gl_x   = PW'({1'b0, gl_sh[idx]});
      gr_x   = PW'({1'b0, gr_sh[idx]});
      prod_l = in_x * gl_x;
      prod_r = in_x * gr_x;
      sat_l  = sat_fn(acc_l);
      sat_r  = sat_fn(acc_r);
   end

   // Mix sequencer: snapshot on strobe, accumulate one channel per cycle, saturate.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state  <= IDLE;
         idx    <= '0;
         acc_l  <= '0;
         acc_r  <= '0;
         left   <= '0;
         right  <= '0;
         sample <= 1'b0;
         clip   <= 1'b0;
         busy   <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            in_sh[c] <= '0;
            gl_sh[c] <= '0;
            gr_sh[c] <= '0;
         end
      end else begin
         sample <= 1'b0;
         clip   <= 1'b0;
         case (state)
            IDLE: begin
               if (cen_smp) begin
                  for (int c = 0; c < CH; c++) begin
                     in_sh[c] <= ch_in[c*IW +: IW];
                     gl_sh[c] <= gain_l[c];
                     gr_sh[c] <= gain_r[c];
                  end
                  acc_l <= '0;
                  acc_r <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= ACC;
               end
            end
            ACC: begin
               acc_l <= acc_l + ACW'(prod_l);
               acc_r <= acc_r + ACW'(prod_r);
               if (idx == LAST) begin
                  state <= SAT;
               end else begin
                  idx <= idx + CW'(1);
               end
            end
            SAT: begin
               left   <= sat_l[OW-1:0];
               right  <= sat_r[OW-1:0];
               sample <= 1'b1;
               clip   <= sat_l[OW] | sat_r[OW];
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/jtdd_snd_mix.md
# jtdd_snd_mix

Parametrised multi-channel stereo sound mixer for the sound subsystem. It replaces the fixed, unsaturated FM-plus-ADPCM adder with a time-multiplexed multiply-accumulate engine. It has per-channel left/right gain registers that the sound CPU can write, and it saturates the output. On each sample strobe it mixes CH signed sources into one stereo sample and raises a clip indication.

## Interface
Parameters:
- CH, 4: number of input channels, 1..8.
- IW, 16: width of each signed input channel.
- GW, 8: width of each unsigned gain register.
- FRAC, 4: fractional bits of the gain; unity is 1<<FRAC.
- OW, 16: width of each signed output.
- AW, derived: clog2(CH)+1, the gain-address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstb  in  1  synchronous reset, active low.
- cen_smp  in  1  sample strobe, one cycle wide.
- ch_in  in  CH*IW  packed signed inputs; channel 0 in the LSBs.
- cs  in  1  gain-register chip select.
- wr_n  in  1  write strobe, active low.
- addr  in  AW  bit 0 selects the side (0 = left, 1 = right); bits [AW-1:1] hold the channel index.
- din  in  GW  gain value.
- left  out  OW  signed mixed left sample.
- right  out  OW  signed mixed right sample.
- sample  out  1  one-cycle pulse when left/right update.
- clip  out  1  one-cycle pulse, coincident with sample, if either side saturated.
- busy  out  1  high while a mix is in progress.

## Operation
- Gain bank: 2*CH registers of GW bits.
  - Reset value is 1<<FRAC (unity) for every register.
  - The register at addr is written on every clk edge where cs=1 and wr_n=0; level writes are idempotent.
  - Writes whose channel index is ≥ CH are ignored.
  - Writes are accepted in every state.
- State machine has three states: IDLE, ACC, SAT.
  - IDLE: when cen_smp=1, snapshot ch_in and the whole gain bank into shadow registers, clear both accumulators, set idx=0, and go to ACC.
  - ACC: each cycle, accL += in[idx]*gL[idx] and accR += in[idx]*gR[idx].
    - The gain is zero-extended and the product is signed, IW+GW+1 bits.
    - idx increments each cycle; after idx=CH-1, go to SAT.
  - SAT: each accumulator is arithmetic-shifted right by FRAC (truncation toward −inf), then clamped to [−2^(OW−1), 2^(OW−1)−1].
    - Register left/right, pulse sample=1, pulse clip=1 if either side clamped, then return to IDLE.
- Accumulator width is IW+GW+1+clog2(CH); no intermediate overflow is possible.
- Gain changes made during ACC/SAT do not affect the sample in progress; they apply from the next strobe. The same holds for ch_in changes.
- cen_smp while not in IDLE is ignored: no queueing, no error.
- Reset values: left=0, right=0, sample=0, clip=0, busy=0, state=IDLE, all gains unity.
- Reset asserted mid-mix aborts the mix. No sample pulse is produced and the outputs return to 0.

## Timing
- A strobe accepted at edge T gives ACC on edges T+1..T+CH and SAT on edge T+CH+1.
- left/right/sample/clip are valid in the cycle after edge T+CH+1. Latency is CH+1 clocks.
- busy is high from after edge T until after edge T+CH+1, i.e. CH+1 cycles.
- The earliest next accepted strobe is at edge T+CH+2, so the minimum strobe period is CH+2 clocks.
- left/right hold their value between sample pulses.
- A gain write at edge W is visible to the snapshot at edge W+1 or later. A write coinciding with the strobe edge is not captured.

## Test plan
CH=4, IW=16, GW=8, FRAC=4, OW=16 unless noted.
- Reset and basic mix:
  - Hold rstb=0 for 3 cycles -> all outputs 0.
  - Then apply ch_in={16, −50, 200, 100} (ch3..ch0) with unity gains, strobe at T -> left=right=266 after edge T+5, sample high exactly one cycle, clip=0, busy high 5 cycles.
- Saturation:
  - All inputs 0x7FFF, unity gain -> left=right=0x7FFF, clip=1.
  - All inputs 0x8000 -> 0x8000, clip=1.
  - Inputs 0x7FFF,1,0,0 -> 0x7FFF, clip=1.
- Pan and gain:
  - Write ch1-left=0x00 and ch1-right=0x20; ch1=1000, others 0 -> left=0, right=2000.
  - Set ch0-left=0x08; ch0=−1, others 0 -> left=−1 (truncation toward −inf), right=−1.
- Shadowing:
  - Write ch0-left=0x08 at T+2 during a mix with ch0=1000 -> that sample has left=1000; the next strobe gives left=500.
  - Changing ch_in at T+1 does not alter the result.
- Busy and reset boundaries:
  - Strobes at T and T+3 -> exactly one sample pulse, at T+5.
  - A strobe at T+6 is accepted.
  - rstb=0 at T+3 -> no sample pulse, outputs 0, gains back to unity.
- Out-of-range write with CH=3, AW=3:
  - Write addr={ch 3, left}=0x00 -> all ch0..ch2 gains unchanged and the mix result is unchanged.
